// File: rtl/gpio_irq_pkg.sv
// Purpose: shared register-map constants and decode types for the gpio_irq peripheral.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gpio_irq_pkg;

    // The peripheral occupies an 8-word (32-byte) aligned window.
    localparam int unsigned RegWords   = 8;
    localparam int unsigned WindowBits = 5;
    localparam int unsigned IdxBits    = WindowBits - 2;

    typedef logic [IdxBits-1:0] reg_idx_t;

    // Word indices inside the window.
    localparam reg_idx_t REG_IN      = 3'd0;
    localparam reg_idx_t REG_OUT     = 3'd1;
    localparam reg_idx_t REG_DIR     = 3'd2;
    localparam reg_idx_t REG_RISE_EN = 3'd3;
    localparam reg_idx_t REG_FALL_EN = 3'd4;
    localparam reg_idx_t REG_PEND    = 3'd5;
    localparam reg_idx_t REG_OUT_SET = 3'd6;
    localparam reg_idx_t REG_OUT_CLR = 3'd7;

    // One decoded bus access.
    typedef struct packed {
        logic     hit;
        logic     we;
        reg_idx_t idx;
    } bus_dec_t;

endpackage

// File: rtl/gpio_sync.sv
// Purpose: Width-bit multi-flop synchroniser for asynchronous level inputs.
// Latency: a change stable before edge e appears on sync_out after edge e+Stages-1.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset, clears every stage
//   async_in  raw asynchronous inputs
//   sync_out  inputs retimed into the clk domain
module gpio_sync #(
    parameter int unsigned Width  = 1,
    parameter int unsigned Stages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] async_in,
    output logic [Width-1:0] sync_out
);

    // stage_q[0] is the metastability-exposed flop; the last stage is the output.
    logic [Stages-1:0][Width-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= async_in;
            for (int i = 1; i < int'(Stages); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_out = stage_q[Stages-1];

endmodule

// File: rtl/gpio_irq.sv
// Purpose: memory-mapped GPIO with per-pin direction, atomic set/clear, edge-detect pending bits and a level irq.
// Latency: every hit is acked exactly one cycle after the request; writes land on the request edge.
// Backpressure: none; accepts one access per cycle, back-to-back requests are each acked.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   bus_req/bus_we     one-cycle access strobe and write select
//   bus_addr/bus_wdata byte address and write data
//   bus_rdata/bus_ack  read data (0 unless acking a read) and completion strobe
//   pin_in             raw asynchronous pad inputs
//   pin_out/pin_oe     output values and output enables (1 = drive)
//   irq                level interrupt, high while any pending bit is set
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int unsigned              DataWidth    = 32,
    parameter int unsigned              AddressWidth = 32,
    parameter logic [AddressWidth-1:0]  BaseAddress  = '0,
    parameter int unsigned              NumIO        = 22,
    parameter logic [DataWidth-1:0]     Mask         = '1,
    parameter int unsigned              SyncStages   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bus_req,
    input  logic                    bus_we,
    input  logic [AddressWidth-1:0] bus_addr,
    input  logic [DataWidth-1:0]    bus_wdata,
    output logic [DataWidth-1:0]    bus_rdata,
    output logic                    bus_ack,
    input  logic [NumIO-1:0]        pin_in,
    output logic [NumIO-1:0]        pin_out,
    output logic [NumIO-1:0]        pin_oe,
    output logic                    irq
);

    // Pins outside the implement mask are inert: they never store, drive or interrupt.
    localparam logic [NumIO-1:0] IoMask = Mask[NumIO-1:0];

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [NumIO-1:0] sin_raw;
    logic [NumIO-1:0] sin;

    gpio_sync #(
        .Width  (NumIO),
        .Stages (SyncStages)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (pin_in),
        .sync_out (sin_raw)
    );

    assign sin = sin_raw & IoMask;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    bus_dec_t         dec;
    logic             wr_hit;
    logic             rd_hit;
    logic [NumIO-1:0] wdat;

    always_comb begin
        dec     = '0;
        dec.hit = bus_req
                  && (bus_addr[AddressWidth-1:WindowBits] == BaseAddress[AddressWidth-1:WindowBits]);
        dec.we  = bus_we;
        dec.idx = bus_addr[WindowBits-1:2];
    end

    assign wr_hit = dec.hit && dec.we;
    assign rd_hit = dec.hit && !dec.we;
    assign wdat   = bus_wdata[NumIO-1:0] & IoMask;

    // Byte-lane bits and the data bits above NumIO carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [NumIO-1:0]     out_q,     out_d;
    logic [NumIO-1:0]     dir_q,     dir_d;
    logic [NumIO-1:0]     rise_en_q, rise_en_d;
    logic [NumIO-1:0]     fall_en_q, fall_en_d;
    logic [NumIO-1:0]     pend_q,    pend_d;
    logic [NumIO-1:0]     prev_q;
    logic                 ack_q;
    logic [DataWidth-1:0] rdata_q,   rdata_d;

    logic [NumIO-1:0] pend_clr;
    logic [NumIO-1:0] rise;
    logic [NumIO-1:0] fall;

    // Control register writes. OUT_SET/OUT_CLR modify OUT in one access so
    // software sharing the port never needs a read-modify-write.
    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        pend_clr  = '0;
        if (wr_hit) begin
            case (dec.idx)
                REG_OUT:     out_d     = wdat;
                REG_DIR:     dir_d     = wdat;
                REG_RISE_EN: rise_en_d = wdat;
                REG_FALL_EN: fall_en_d = wdat;
                REG_PEND:    pend_clr  = wdat;
                REG_OUT_SET: out_d     = out_q | wdat;
                REG_OUT_CLR: out_d     = out_q & ~wdat;
                default:     ;
            endcase
        end
    end

    // Edge detection compares the synchronised value with last cycle's copy.
    // Direction is deliberately ignored, so a pin looped back from its own
    // output still flags edges. New edges are ORed in after the clear, so an
    // edge and a write-1-to-clear on the same bit in the same cycle keep it set.
    always_comb begin
        rise   = sin & ~prev_q & rise_en_q;
        fall   = ~sin & prev_q & fall_en_q;
        pend_d = ((pend_q & ~pend_clr) | rise | fall) & IoMask;
    end

    // Read mux. Data only accompanies read acks; writes and misses return 0 so
    // the bus can OR rdata from several peripherals.
    always_comb begin
        rdata_d = '0;
        if (rd_hit) begin
            case (dec.idx)
                REG_IN:      rdata_d[NumIO-1:0] = sin;
                REG_OUT:     rdata_d[NumIO-1:0] = out_q;
                REG_DIR:     rdata_d[NumIO-1:0] = dir_q;
                REG_RISE_EN: rdata_d[NumIO-1:0] = rise_en_q;
                REG_FALL_EN: rdata_d[NumIO-1:0] = fall_en_q;
                REG_PEND:    rdata_d[NumIO-1:0] = pend_q;
                default:     rdata_d            = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            prev_q    <= sin;
            ack_q     <= dec.hit;
            rdata_q   <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_ack   = ack_q;
    assign bus_rdata = rdata_q;
    assign pin_out   = out_q & IoMask;
    assign pin_oe    = dir_q & IoMask;
    assign irq       = |pend_q;

endmodule
